// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared types and default sizing for the ADC capture controller.
// The optional trigger-arm phase is enabled by defining ADC_CAPTURE_TRIG_EN.

package adc_capture_pkg;

   localparam int ADC_NUM_CH_DEF = 2;
   localparam int ADC_CNT_W_DEF  = 16;

   typedef enum logic [3:0] {
      IDLE   = 4'b0001,
      ARM    = 4'b0010,
      BUFFER = 4'b0100,
      DRAIN  = 4'b1000
   } capture_state_t;

endpackage

// File: rtl/capture_len_counter.sv
// capture_len_counter: loadable, clearable up-counter that saturates at all-ones.
// tc flags count == tc_val so the owner can end a burst on the cycle that makes
// the programmed number of writes.

module capture_len_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             inc,
   input  logic [CNT_W-1:0] tc_val,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   logic [CNT_W-1:0] count_q;

   // Clear beats load beats increment; increment stops at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count = count_q;
   assign tc    = (count_q == tc_val);

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: gates per-channel FIFO writes for fixed-length or
// fill-until-full capture bursts, waits for readout to drain the enabled FIFOs,
// then finishes or re-arms. Define ADC_CAPTURE_TRIG_EN to add the trig input and
// an ARM phase that holds off each burst until trig is seen.
//
// state  | meaning
// IDLE   | waiting for start with a non-zero channel mask
// ARM    | (trigger build only) waiting for trig before writing
// BUFFER | writing the latched channel mask every cycle
// DRAIN  | writes stopped, waiting for every enabled FIFO to read empty

module adc_capture_ctrl
   import adc_capture_pkg::*;
#(
   parameter int NUM_CH = ADC_NUM_CH_DEF,
   parameter int CNT_W  = ADC_CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rstn,
`ifdef ADC_CAPTURE_TRIG_EN
   input  logic              trig,
`endif
   input  logic              start,
   input  logic              abort,
   input  logic              continuous,
   input  logic [CNT_W-1:0]  capture_len,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic [NUM_CH-1:0] fifo_full,
   input  logic [NUM_CH-1:0] fifo_empty,
   output logic [NUM_CH-1:0] wr_en,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  sample_cnt,
   output logic              trunc
);

`ifdef ADC_CAPTURE_TRIG_EN
   localparam capture_state_t BURST_ENTRY = ARM;
`else
   localparam capture_state_t BURST_ENTRY = BUFFER;
`endif

   capture_state_t    state_q;
   capture_state_t    state_nxt;

   logic [NUM_CH-1:0] ch_en_q;
   logic [CNT_W-1:0]  cap_len_q;
   logic              done_q;
   logic              trunc_q;

   logic              do_latch;
   logic              cnt_clr;
   logic              cnt_inc;
   logic              trunc_set;
   logic              done_nxt;

   logic              full_hit;
   logic              all_empty;
   logic              len_hit;
   logic              cnt_tc;
   logic [CNT_W-1:0]  cnt_val;
   logic [CNT_W-1:0]  tc_val;

   // Disabled channels never stop a burst nor hold off the drain.
   assign full_hit  = |(fifo_full & ch_en_q);
   assign all_empty = &(fifo_empty | ~ch_en_q);

   // Terminal count sits one below the length so the compare fires on the last write.
   assign tc_val  = cap_len_q - CNT_W'(1);
   assign len_hit = (cap_len_q != '0) && cnt_tc;

   capture_len_counter #(
      .CNT_W (CNT_W)
   ) u_len_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .clr      (cnt_clr),
      .load     (1'b0),
      .load_val ('0),
      .inc      (cnt_inc),
      .tc_val   (tc_val),
      .count    (cnt_val),
      .tc       (cnt_tc)
   );

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next state and per-cycle control strobes; abort overrides everything and leaves counters alone.
   always_comb begin
      state_nxt = state_q;
      do_latch  = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      trunc_set = 1'b0;
      done_nxt  = 1'b0;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && (ch_en != '0)) begin
                  do_latch  = 1'b1;
                  cnt_clr   = 1'b1;
                  state_nxt = BURST_ENTRY;
               end
            end
            ARM: begin
`ifdef ADC_CAPTURE_TRIG_EN
               if (trig) begin
                  state_nxt = BUFFER;
               end
`else
               state_nxt = IDLE;
`endif
            end
            BUFFER: begin
               cnt_inc = 1'b1;
               if (len_hit || full_hit) begin
                  state_nxt = DRAIN;
                  trunc_set = full_hit && !len_hit;
               end
            end
            DRAIN: begin
               if (all_empty) begin
                  if (continuous) begin
                     cnt_clr   = 1'b1;
                     state_nxt = BURST_ENTRY;
                  end else begin
                     done_nxt  = 1'b1;
                     state_nxt = IDLE;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Channel mask and length are frozen for the whole capture once start is accepted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ch_en_q   <= '0;
         cap_len_q <= '0;
      end else if (do_latch) begin
         ch_en_q   <= ch_en;
         cap_len_q <= capture_len;
      end
   end

   // Completion pulse and sticky truncation flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         done_q  <= 1'b0;
         trunc_q <= 1'b0;
      end else begin
         done_q <= done_nxt;
         if (do_latch) begin
            trunc_q <= 1'b0;
         end else if (trunc_set) begin
            trunc_q <= 1'b1;
         end
      end
   end

   assign wr_en      = (state_q == BUFFER) ? ch_en_q : '0;
   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign sample_cnt = cnt_val;
   assign trunc      = trunc_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: self-checking bench for adc_capture_ctrl with a
// burst-level reference model (writes = min(length limit, full limit)).

module tb_adc_capture_ctrl;

   localparam int NCH = 2;
   localparam int CW  = 16;
   localparam int INF = 1 << 30;
`ifdef ADC_CAPTURE_TRIG_EN
   localparam int ARM_LAT = 1;
`else
   localparam int ARM_LAT = 0;
`endif

   logic           clk = 1'b0;
   logic           rstn;
   logic           trig;
   logic           start;
   logic           abort;
   logic           continuous;
   logic [CW-1:0]  capture_len;
   logic [NCH-1:0] ch_en;
   logic [NCH-1:0] fifo_full;
   logic [NCH-1:0] fifo_empty;
   logic [NCH-1:0] wr_en;
   logic           busy;
   logic           done;
   logic [CW-1:0]  sample_cnt;
   logic           trunc;

   int checks   = 0;
   int failures = 0;

   adc_capture_ctrl #(
      .NUM_CH (NCH),
      .CNT_W  (CW)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
`ifdef ADC_CAPTURE_TRIG_EN
      .trig        (trig),
`endif
      .start       (start),
      .abort       (abort),
      .continuous  (continuous),
      .capture_len (capture_len),
      .ch_en       (ch_en),
      .fifo_full   (fifo_full),
      .fifo_empty  (fifo_empty),
      .wr_en       (wr_en),
      .busy        (busy),
      .done        (done),
      .sample_cnt  (sample_cnt),
      .trunc       (trunc)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Runs one capture; returns what was observed. Called at a negedge with the DUT idle.
   task automatic do_burst(input logic [CW-1:0] len, input logic [NCH-1:0] mask,
                           input logic [NCH-1:0] full_init, input int full_at,
                           input logic [NCH-1:0] full_lines, input int drain_dly,
                           input int bound,
                           output int writes, output bit wr_bad,
                           output logic [CW-1:0] cnt_end, output logic trunc_end,
                           output bit drain_bad, output logic done_end,
                           output logic busy_end, output logic done_after,
                           output bit timeout);
      int cyc;
      writes = 0; wr_bad = 0; drain_bad = 0; timeout = 0; cyc = 0;
      fifo_full = full_init; fifo_empty = '0; continuous = 1'b0;
      start = 1'b1; ch_en = mask; capture_len = len;
      @(negedge clk);
      start = 1'b0; ch_en = NCH'($urandom); capture_len = CW'($urandom);
      repeat (ARM_LAT) @(negedge clk);
      while (wr_en != '0 && cyc < bound) begin
         if (wr_en !== mask) wr_bad = 1;
         if (writes == full_at) fifo_full = fifo_full | full_lines;
         start = 1'($urandom_range(0, 1));
         writes++; cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      if (cyc >= bound) timeout = 1;
      cnt_end = sample_cnt; trunc_end = trunc;
      for (int i = 0; i < drain_dly; i++) begin
         fifo_empty = ~mask;
         @(negedge clk);
         if (busy !== 1'b1 || done !== 1'b0 || wr_en !== '0) drain_bad = 1;
      end
      fifo_empty = mask; fifo_full = '0;
      @(negedge clk);
      done_end = done; busy_end = busy;
      fifo_empty = '0;
      @(negedge clk);
      done_after = done;
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      #1;
      checks++;
      if (wr_en !== '0 || busy !== 1'b0 || done !== 1'b0 || sample_cnt !== '0 || trunc !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: wr_en=%b busy=%b done=%b cnt=%0d trunc=%b required all zero",
                  wr_en, busy, done, sample_cnt, trunc);
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || wr_en !== '0) begin
         failures++;
         $display("FAIL reset_release: busy=%b wr_en=%b required 0/00", busy, wr_en);
      end
   endtask

   task automatic test_reset_mid_burst;
      bit bad;
      start = 1'b1; ch_en = 2'b11; capture_len = 8;
      @(negedge clk);
      start = 1'b0;
      repeat (ARM_LAT + 3) @(negedge clk);
      checks++;
      if (wr_en !== 2'b11) begin
         failures++;
         $display("FAIL reset_mid_precond: wr_en=%b required 11", wr_en);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if (wr_en !== '0 || busy !== 1'b0 || done !== 1'b0 || sample_cnt !== '0 || trunc !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_async: wr_en=%b busy=%b done=%b cnt=%0d trunc=%b required all zero",
                  wr_en, busy, done, sample_cnt, trunc);
      end
      @(negedge clk);
      rstn = 1'b1;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (wr_en !== '0 || busy !== 1'b0) bad = 1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL reset_mid_spurious: wr_en=%b busy=%b required idle after reset", wr_en, busy);
      end
   endtask

   task automatic test_len8;
      int w; bit wb, db, to; logic [CW-1:0] c; logic t, d, b, da;
      do_burst(8, 2'b11, 2'b00, -1, 2'b00, 2, 100, w, wb, c, t, db, d, b, da, to);
      checks++;
      if (to || w != 8 || wb) begin
         failures++;
         $display("FAIL len8_writes: writes=%0d wr_bad=%0d timeout=%0d required 8/0/0", w, wb, to);
      end
      checks++;
      if (c !== 16'd8 || t !== 1'b0) begin
         failures++;
         $display("FAIL len8_cnt_trunc: cnt=%0d trunc=%b required 8/0", c, t);
      end
      checks++;
      if (db || d !== 1'b1 || b !== 1'b0 || da !== 1'b0) begin
         failures++;
         $display("FAIL len8_done: drain_bad=%0d done=%b busy=%b done_next=%b required 0/1/0/0", db, d, b, da);
      end
   endtask

   task automatic test_len0_full;
      int w; bit wb, db, to; logic [CW-1:0] c; logic t, d, b, da;
      do_burst(0, 2'b11, 2'b00, 5, 2'b01, 1, 100, w, wb, c, t, db, d, b, da, to);
      checks++;
      if (to || w != 6 || wb) begin
         failures++;
         $display("FAIL len0_full_writes: writes=%0d wr_bad=%0d timeout=%0d required 6/0/0", w, wb, to);
      end
      checks++;
      if (c !== 16'd6 || t !== 1'b1 || d !== 1'b1) begin
         failures++;
         $display("FAIL len0_full_status: cnt=%0d trunc=%b done=%b required 6/1/1", c, t, d);
      end
   endtask

   task automatic test_disabled_full;
      int w; bit wb, db, to; logic [CW-1:0] c; logic t, d, b, da;
      do_burst(4, 2'b01, 2'b10, -1, 2'b00, 1, 100, w, wb, c, t, db, d, b, da, to);
      checks++;
      if (to || w != 4 || wb || c !== 16'd4 || t !== 1'b0) begin
         failures++;
         $display("FAIL disabled_full: writes=%0d wr_bad=%0d cnt=%0d trunc=%b required 4/0/4/0", w, wb, c, t);
      end
      checks++;
      if (d !== 1'b1 || b !== 1'b0) begin
         failures++;
         $display("FAIL disabled_empty_done: done=%b busy=%b required 1/0", d, b);
      end
   endtask

   task automatic test_full_and_len_same;
      int w; bit wb, db, to; logic [CW-1:0] c; logic t, d, b, da;
      do_burst(5, 2'b10, 2'b00, 4, 2'b10, 0, 100, w, wb, c, t, db, d, b, da, to);
      checks++;
      if (to || w != 5 || c !== 16'd5 || t !== 1'b0) begin
         failures++;
         $display("FAIL full_len_same: writes=%0d cnt=%0d trunc=%b required 5/5/0", w, c, t);
      end
   endtask

   task automatic test_random;
      int w, exp_w, n_len, n_full, full_at; bit wb, db, to, exp_t;
      logic [CW-1:0] c, len, exp_c; logic t, d, b, da;
      logic [NCH-1:0] mask, finit, flines;
      for (int it = 0; it < 12; it++) begin
         mask    = NCH'($urandom_range(1, 3));
         len     = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 20));
         finit   = ($urandom_range(0, 5) == 0) ? NCH'($urandom) : '0;
         full_at = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 24);
         flines  = NCH'($urandom);
         if (len == '0 && (finit & mask) == '0) begin
            if (full_at < 0) full_at = $urandom_range(0, 24);
            flines = flines | mask;
         end
         n_len  = (len == '0) ? INF : int'(len);
         if ((finit & mask) != '0) n_full = 1;
         else if (full_at >= 0 && (flines & mask) != '0) n_full = full_at + 1;
         else n_full = INF;
         exp_w = (n_full < n_len) ? n_full : n_len;
         exp_t = (n_full < n_len);
         exp_c = CW'(exp_w);
         do_burst(len, mask, finit, full_at, flines, $urandom_range(0, 3), 100,
                  w, wb, c, t, db, d, b, da, to);
         checks++;
         if (to || w != exp_w || wb || c !== exp_c || t !== exp_t) begin
            failures++;
            $display("FAIL random_burst[%0d]: writes=%0d cnt=%0d trunc=%b wr_bad=%0d required %0d/%0d/%b/0",
                     it, w, c, t, wb, exp_w, exp_c, exp_t);
         end
         checks++;
         if (db || d !== 1'b1 || b !== 1'b0 || da !== 1'b0) begin
            failures++;
            $display("FAIL random_done[%0d]: drain_bad=%0d done=%b busy=%b done_next=%b required 0/1/0/0",
                     it, db, d, b, da);
         end
      end
   endtask

   task automatic test_zero_mask_start;
      logic [CW-1:0] cnt_before;
      cnt_before = sample_cnt;
      start = 1'b1; ch_en = '0; capture_len = 3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || wr_en !== '0 || sample_cnt !== cnt_before) begin
         failures++;
         $display("FAIL zero_mask_start: busy=%b wr_en=%b cnt=%0d required 0/00/%0d",
                  busy, wr_en, sample_cnt, cnt_before);
      end
   endtask

   task automatic test_abort;
      bit bad;
      continuous = 1'b0; fifo_full = '0; fifo_empty = '0;
      start = 1'b1; ch_en = 2'b11; capture_len = 10;
      @(negedge clk);
      start = 1'b0;
      repeat (ARM_LAT + 3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || wr_en !== '0 || sample_cnt !== 16'd3 || done !== 1'b0) begin
         failures++;
         $display("FAIL abort_buffer: busy=%b wr_en=%b cnt=%0d done=%b required 0/00/3/0",
                  busy, wr_en, sample_cnt, done);
      end
      start = 1'b1; abort = 1'b1; capture_len = 5;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || sample_cnt !== 16'd3) begin
         failures++;
         $display("FAIL abort_beats_start: busy=%b cnt=%0d required 0/3", busy, sample_cnt);
      end
      start = 1'b1; capture_len = 2; ch_en = 2'b01;
      @(negedge clk);
      start = 1'b0;
      repeat (ARM_LAT + 2) @(negedge clk);
      abort = 1'b1; fifo_empty = 2'b11;
      @(negedge clk);
      abort = 1'b0;
      bad = (done !== 1'b0);
      @(negedge clk);
      if (done !== 1'b0) bad = 1;
      fifo_empty = '0;
      checks++;
      if (bad || busy !== 1'b0 || sample_cnt !== 16'd2 || trunc !== 1'b0) begin
         failures++;
         $display("FAIL abort_drain: done_seen=%0d busy=%b cnt=%0d trunc=%b required 0/0/2/0",
                  bad, busy, sample_cnt, trunc);
      end
   endtask

   task automatic test_continuous;
      int w, cyc; bit bad;
      continuous = 1'b1; fifo_full = '0; fifo_empty = '0;
      start = 1'b1; ch_en = 2'b10; capture_len = 3;
      @(negedge clk);
      start = 1'b0; capture_len = 9; ch_en = 2'b11;
      repeat (ARM_LAT) @(negedge clk);
      for (int bst = 0; bst < 4; bst++) begin
         w = 0; cyc = 0; bad = 0;
         while (wr_en != '0 && cyc < 50) begin
            if (wr_en !== 2'b10 || done !== 1'b0) bad = 1;
            w++; cyc++;
            @(negedge clk);
         end
         checks++;
         if (w != 3 || bad) begin
            failures++;
            $display("FAIL cont_burst[%0d]: writes=%0d bad=%0d required 3/0", bst, w, bad);
         end
         if (bst == 3) continuous = 1'b0;
         fifo_empty = 2'b10;
         @(negedge clk);
         fifo_empty = '0;
         repeat ((bst < 3) ? ARM_LAT : 0) @(negedge clk);
         if (bst < 3) begin
            checks++;
            if (wr_en !== 2'b10 || done !== 1'b0 || busy !== 1'b1 || sample_cnt !== '0) begin
               failures++;
               $display("FAIL cont_rearm[%0d]: wr_en=%b done=%b busy=%b cnt=%0d required 10/0/1/0",
                        bst, wr_en, done, busy, sample_cnt);
            end
         end else begin
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || wr_en !== '0) begin
               failures++;
               $display("FAIL cont_final_done: done=%b busy=%b wr_en=%b required 1/0/00", done, busy, wr_en);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_saturate;
      int w; bit wb, db, to; logic [CW-1:0] c; logic t, d, b, da;
      do_burst(0, 2'b01, 2'b00, 65540, 2'b01, 0, 70000, w, wb, c, t, db, d, b, da, to);
      checks++;
      if (to || w != 65541 || c !== 16'hffff || t !== 1'b1 || d !== 1'b1) begin
         failures++;
         $display("FAIL saturate: writes=%0d cnt=%0d trunc=%b done=%b required 65541/65535/1/1", w, c, t, d);
      end
   endtask

`ifdef ADC_CAPTURE_TRIG_EN
   task automatic test_trig;
      bit bad;
      trig = 1'b0; continuous = 1'b0; fifo_full = '0; fifo_empty = '0;
      start = 1'b1; ch_en = 2'b11; capture_len = 4;
      bad = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (wr_en !== '0 || busy !== 1'b1) bad = 1;
      end
      trig = 1'b1;
      @(negedge clk);
      checks++;
      if (bad || wr_en !== 2'b11) begin
         failures++;
         $display("FAIL trig_arm: early_or_idle=%0d wr_en=%b required 0/11", bad, wr_en);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
   endtask
`endif

   initial begin
      rstn = 1'b0; trig = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
      capture_len = '0; ch_en = '0; fifo_full = '0; fifo_empty = '0;
      @(negedge clk);
      test_reset;
      test_reset_mid_burst;
      test_len8;
      test_len0_full;
      test_disabled_full;
      test_full_and_len_same;
      test_zero_mask_start;
      test_abort;
      test_continuous;
      test_random;
`ifdef ADC_CAPTURE_TRIG_EN
      test_trig;
`endif
      test_saturate;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Parametrised capture controller gating writes from NUM_CH ADC channels into per-channel sample FIFOs. Per capture it runs a fixed-length or fill-until-full write burst, waits for downstream readout to drain every enabled FIFO, then either finishes or re-arms in continuous mode. It sits between the ADC deserialiser/FIFO bank and the readout logic; all control inputs are synchronous to `clk`.

## Interface
- `NUM_CH`, 2: number of channels/FIFOs (1..16).
- `CNT_W`, 16: width of capture length and sample counter.

- `clk`  in  1  system clock; single clock domain.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin capture; only acted on in IDLE.
- `abort`  in  1  cancel capture from any state.
- `continuous`  in  1  re-arm after each drain; sampled every DRAIN exit.
- `capture_len`  in  CNT_W  samples per capture; 0 = write until any FIFO full. Latched at start.
- `ch_en`  in  NUM_CH  channel enable mask; latched at start.
- `fifo_full`  in  NUM_CH  per-channel FIFO full.
- `fifo_empty`  in  NUM_CH  per-channel FIFO empty.
- `wr_en`  out  NUM_CH  per-channel FIFO write enable.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse on capture completion.
- `sample_cnt`  out  CNT_W  write cycles in current burst.
- `trunc`  out  1  sticky: last burst ended by full before capture_len; cleared at start.

## Operation
- States (one-hot): IDLE, ARM, BUFFER, DRAIN. ARM exists only with the config macro.
- IDLE: on `start`=1 and `ch_en`≠0, latch `ch_en`/`capture_len`, clear `sample_cnt` and `trunc`, go BUFFER (ARM with macro). `start` with `ch_en`=0 is ignored.
- BUFFER: `wr_en` = latched mask; `sample_cnt` += 1 per cycle. Exit to DRAIN when `capture_len`≠0 and `sample_cnt`==`capture_len`−1 (exactly `capture_len` write cycles), or when any enabled `fifo_full`=1.
- Full and length end in the same cycle: `trunc` stays 0. Full alone ends burst: `trunc` set to 1.
- `fifo_full` of disabled channels is ignored; `fifo_empty` likewise.
- DRAIN: `wr_en`=0. When all enabled `fifo_empty`=1: if `continuous`=1, clear `sample_cnt`, go BUFFER (no `done`); else pulse `done`, go IDLE.
- `abort`=1: next state IDLE from any state, `wr_en` low next cycle, no `done`; `sample_cnt` and `trunc` hold. Abort beats start.
- `start` while busy: ignored. `sample_cnt` saturates at all-ones (never wraps) in length-0 mode.

## Timing
- Reset values: state IDLE, `wr_en`=0, `busy`=0, `done`=0, `sample_cnt`=0, `trunc`=0.
- All outputs are decoded from registers; no combinational input-to-output path.
- `start` at cycle t → `busy`, `wr_en` high from t+1.
- Full seen at cycle t → `wr_en` still high at t (the FIFO drops that write), low from t+1.
- Last empty seen at cycle t → `done` high for cycle t+1 only; `busy` low at t+1.
- Continuous re-arm: last empty at t → `wr_en` high at t+1.

## Configuration
- `ADC_CAPTURE_TRIG_EN` defined: adds input `trig` (1 bit). After start, ARM waits with `wr_en`=0, `busy`=1 until `trig`=1, then BUFFER next cycle. Continuous re-arm also passes through ARM. `abort` exits ARM.
- Undefined: no `trig` port, no ARM state; start goes straight to BUFFER.

## Structure
- `adc_capture_pkg`: one-hot state enum `capture_state_t` (IDLE=4'b0001, ARM=4'b0010, BUFFER=4'b0100, DRAIN=4'b1000), default `NUM_CH`/`CNT_W` constants.
- Sub-module `capture_len_counter`: loadable, clearable, saturating CNT_W counter with terminal-count compare output.

## Test plan
- Reset mid-BUFFER, NUM_CH=2, `capture_len`=8 → all outputs at reset values immediately; no spurious `wr_en`.
- `capture_len`=8, `ch_en`=2'b11, FIFOs never full → `wr_en`=2'b11 for exactly 8 cycles; `done` after empties; `trunc`=0.
- `capture_len`=0, `fifo_full[0]` rises after 5 writes → 6 write cycles, `trunc`=1, `sample_cnt`=6.
- `ch_en`=2'b01, `fifo_full[1]`=1 throughout, `capture_len`=4 → `wr_en`=2'b01 for 4 cycles; full on ch1 ignored.
- `continuous`=1, `capture_len`=3, three drains → three bursts, no `done`; drop `continuous` → `done` after next drain.
- `abort` in DRAIN and during `start` in IDLE → IDLE, no `done`; with macro, `trig` 10 cycles after start → first `wr_en` 11 cycles after start.
